// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: blocking CPU-side cache controller.
// Read hits are served from the cache. Read misses refill the whole line from
// memory and install it. Writes are write-through and no-write-allocate.
// Optional feature macro: CACHE_REFILL_CTRL_PERF_EN adds saturating read
// hit/miss counters on the perf_hits/perf_misses outputs.
module cache_refill_ctrl #(
    parameter int unsigned BLOCK_SIZE             = 32,
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = 4,
    parameter int unsigned ADDRESS_SIZE           = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    // CPU side
    input  logic                                         cpu_req,
    input  logic                                         cpu_we,
    input  logic [ADDRESS_SIZE-1:0]                      cpu_addr,
    input  logic [BLOCK_SIZE-1:0]                        cpu_wdata,
    output logic                                         cpu_ready,
    output logic                                         cpu_resp,
    output logic [BLOCK_SIZE-1:0]                        cpu_rdata,
`ifdef CACHE_REFILL_CTRL_PERF_EN
    output logic [31:0]                                  perf_hits,
    output logic [31:0]                                  perf_misses,
`endif
    // Cache side
    output logic                                         c_read,
    output logic                                         c_write,
    output logic                                         c_write_line,
    output logic [ADDRESS_SIZE-1:0]                      c_addr,
    output logic [BLOCK_SIZE-1:0]                        c_wdata,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] c_line,
    input  logic [BLOCK_SIZE-1:0]                        c_rdata,
    input  logic                                         c_hit,
    input  logic                                         c_miss,
    // Memory side
    output logic                                         mem_req,
    output logic                                         mem_we,
    output logic [ADDRESS_SIZE-1:0]                      mem_addr,
    output logic [BLOCK_SIZE-1:0]                        mem_wdata,
    input  logic                                         mem_ack,
    input  logic                                         mem_rvalid,
    input  logic [BLOCK_SIZE-1:0]                        mem_rdata
);

    localparam int unsigned OFS    = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int unsigned LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FILL_REQ,
        FILL_BEAT,
        INSTALL,
        WR_MEM,
        RESP
    } state_t;

    state_t                  r_state;
    logic                    r_we;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [BLOCK_SIZE-1:0]   r_wdata;
    logic [OFS-1:0]          r_beat_cnt;
    logic [LINE_W-1:0]       r_line;
    logic                    r_cpu_ready;
    logic                    r_cpu_resp;
    logic [BLOCK_SIZE-1:0]   r_cpu_rdata;
    logic                    r_c_read;
    logic                    r_c_write;
    logic                    r_c_write_line;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDRESS_SIZE-1:0] r_mem_addr;
    logic [BLOCK_SIZE-1:0]   r_mem_wdata;

    logic [OFS-1:0]          w_off;
    logic [ADDRESS_SIZE-1:0] w_line_addr;
    logic [BLOCK_SIZE-1:0]   w_slot;
    logic                    w_last_beat;

    // Offset of the requested word, its line base address and its slot in the refilled line
    assign w_off       = r_addr[OFS-1:0];
    assign w_line_addr = {r_addr[ADDRESS_SIZE-1:OFS], {OFS{1'b0}}};
    assign w_slot      = r_line[w_off*BLOCK_SIZE +: BLOCK_SIZE];
    assign w_last_beat = (r_beat_cnt == OFS'(NUM_OF_BLOCKS_PER_LINE - 1));

    // Request sequencing FSM; every command/response output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_beat_cnt     <= '0;
            r_line         <= '0;
            r_cpu_ready    <= 1'b1;
            r_cpu_resp     <= 1'b0;
            r_cpu_rdata    <= '0;
            r_c_read       <= 1'b0;
            r_c_write      <= 1'b0;
            r_c_write_line <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
        end else begin
            // Command pulses last one cycle unless re-asserted below
            r_c_read       <= 1'b0;
            r_c_write      <= 1'b0;
            r_c_write_line <= 1'b0;
            r_cpu_resp     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we        <= cpu_we;
                        r_addr      <= cpu_addr;
                        r_wdata     <= cpu_wdata;
                        r_c_read    <= ~cpu_we;
                        r_c_write   <= cpu_we;
                        r_cpu_ready <= 1'b0;
                        r_state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    r_state <= CHECK;
                end

                CHECK: begin
                    if (r_we) begin
                        // Write-through regardless of hit; a write miss never allocates
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= WR_MEM;
                    end else if (c_hit) begin
                        r_cpu_rdata <= c_rdata;
                        r_cpu_resp  <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        // Anything other than a hit refills, so a confused cache cannot wedge us
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= w_line_addr;
                        r_mem_wdata <= '0;
                        r_beat_cnt  <= '0;
                        r_state     <= FILL_REQ;
                    end
                end

                FILL_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= FILL_BEAT;
                    end
                end

                FILL_BEAT: begin
                    if (mem_rvalid) begin
                        r_line[r_beat_cnt*BLOCK_SIZE +: BLOCK_SIZE] <= mem_rdata;
                        r_beat_cnt <= OFS'(r_beat_cnt + 1'b1);
                        if (w_last_beat) begin
                            r_c_write_line <= 1'b1;
                            r_state        <= INSTALL;
                        end
                    end
                end

                INSTALL: begin
                    // The requested word is taken from the refilled line, not re-read from the cache
                    r_cpu_rdata <= w_slot;
                    r_cpu_resp  <= 1'b1;
                    r_state     <= RESP;
                end

                WR_MEM: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_cpu_resp <= 1'b1;
                        r_state    <= RESP;
                    end
                end

                RESP: begin
                    r_cpu_ready <= 1'b1;
                    r_state     <= IDLE;
                end

                default: begin
                    r_cpu_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_REFILL_CTRL_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    // Saturating counters of read lookup outcomes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (r_state == CHECK && !r_we) begin
            if (c_hit) begin
                if (r_perf_hits != '1) r_perf_hits <= r_perf_hits + 32'd1;
            end else begin
                if (r_perf_misses != '1) r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

    assign cpu_ready    = r_cpu_ready;
    assign cpu_resp     = r_cpu_resp;
    assign cpu_rdata    = r_cpu_rdata;
    assign c_read       = r_c_read;
    assign c_write      = r_c_write;
    assign c_write_line = r_c_write_line;
    assign c_addr       = r_addr;
    assign c_wdata      = r_wdata;
    assign c_line       = r_line;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: reactive cache and memory models, a per-transaction
// expectation model and one negedge compare process, plus directed scenarios.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

    localparam int unsigned BS = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned AW = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cpu_req, cpu_we;
    logic [AW-1:0]      cpu_addr;
    logic [BS-1:0]      cpu_wdata;
    logic               cpu_ready, cpu_resp;
    logic [BS-1:0]      cpu_rdata;
    logic               c_read, c_write, c_write_line;
    logic [AW-1:0]      c_addr;
    logic [BS-1:0]      c_wdata;
    logic [NB*BS-1:0]   c_line;
    logic [BS-1:0]      c_rdata;
    logic               c_hit, c_miss;
    logic               mem_req, mem_we;
    logic [AW-1:0]      mem_addr;
    logic [BS-1:0]      mem_wdata;
    logic               mem_ack, mem_rvalid;
    logic [BS-1:0]      mem_rdata;
`ifdef CACHE_REFILL_CTRL_PERF_EN
    logic [31:0]        perf_hits, perf_misses;
`endif

    cache_refill_ctrl #(.BLOCK_SIZE(BS), .NUM_OF_BLOCKS_PER_LINE(NB), .ADDRESS_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
`ifdef CACHE_REFILL_CTRL_PERF_EN
        .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
        .c_read(c_read), .c_write(c_write), .c_write_line(c_write_line),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_line(c_line),
        .c_rdata(c_rdata), .c_hit(c_hit), .c_miss(c_miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [NB*BS-1:0] act, input logic [NB*BS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scenario configuration (what the environment will answer)
    bit            cfg_we, cfg_hit;
    logic [AW-1:0] cfg_addr;
    logic [BS-1:0] cfg_wdata, cfg_crdata;
    logic [BS-1:0] cfg_beats [NB];
    int            ack_delay  = 0;
    int            beat_limit = NB;
    int            beats_sent = 0;

    // Cache model: registered result the cycle after a c_read/c_write pulse
    bit c_pend = 1'b0;
    always @(negedge clk) c_pend = c_read | c_write;
    initial begin
        c_hit = 1'b0; c_miss = 1'b0; c_rdata = '0;
        forever begin
            @(posedge clk); #1;
            c_hit   = c_pend & cfg_hit;
            c_miss  = c_pend & !cfg_hit;
            c_rdata = c_pend ? cfg_crdata : '0;
        end
    end

    // Memory model: ack after ack_delay extra cycles, then line beats for reads
    initial begin
        int req_cycles = 0;
        int beat_pos   = 0;
        bit beats_on   = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!rst_n) beats_on = 1'b0;
            if (beats_on) begin
                mem_rvalid = 1'b1;
                mem_rdata  = cfg_beats[beat_pos];
                beat_pos++;
                beats_sent++;
                if (beat_pos >= beat_limit) beats_on = 1'b0;
            end
            if (!mem_req) begin
                req_cycles = 0;
                mem_ack    = 1'b0;
            end else begin
                req_cycles++;
                mem_ack = (req_cycles > ack_delay);
                if (mem_ack && !mem_we) begin
                    beats_on = 1'b1;
                    beat_pos = 0;
                end
            end
        end
    end

    // Transaction model state and observations
    bit            outst = 1'b0;
    int            age;
    bit            t_we, t_hit;
    logic [AW-1:0] t_addr;
    logic [BS-1:0] t_wdata, t_crdata;
    logic [BS-1:0] t_beats [NB];
    int            o_cread, o_cwrite, o_wl, o_memrise, o_memhigh, o_lat, n_done = 0;
    logic [AW-1:0] o_maddr;
    logic [BS-1:0] o_mwdata, o_rdata;
    logic [NB*BS-1:0] o_line;
    bit            prev_mreq = 1'b0;
    int            m_hits = 0, m_misses = 0;

    // Acceptance: the bench only raises cpu_req while it has nothing outstanding
    always @(posedge clk) begin
        if (rst_n && cpu_req && !outst) begin
            outst = 1'b1; age = 0;
            t_we = cfg_we; t_hit = cfg_hit; t_addr = cfg_addr;
            t_wdata = cfg_wdata; t_crdata = cfg_crdata;
            for (int k = 0; k < NB; k++) t_beats[k] = cfg_beats[k];
            o_cread = 0; o_cwrite = 0; o_wl = 0; o_memrise = 0; o_memhigh = 0; o_lat = 0;
            o_maddr = '0; o_mwdata = '0; o_rdata = '0; o_line = '0;
        end
    end

    // Compare process: checks DUT outputs against the model every cycle
    always @(negedge clk) begin
        logic [NB*BS-1:0] exp_line;
        logic [AW-1:0]    exp_maddr;
        logic [BS-1:0]    exp_rdata;
        for (int k = 0; k < NB; k++) exp_line[k*BS +: BS] = t_beats[k];
        exp_maddr = t_we ? t_addr : (t_addr / NB) * NB;
        exp_rdata = t_hit ? t_crdata : t_beats[t_addr % NB];
        if (!rst_n) begin
            outst = 1'b0; m_hits = 0; m_misses = 0;
            chk("rst_ready", cpu_ready, 1);
            chk("rst_resp", cpu_resp, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_write_line", c_write_line, 0);
            chk("rst_c_line", c_line, 0);
            chk("rst_c_addr", c_addr, 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
        end else if (!outst) begin
            chk("idle_ready", cpu_ready, 1);
            chk("idle_resp", cpu_resp, 0);
            chk("idle_cmd", {c_read, c_write, c_write_line}, 0);
            chk("idle_mem_req", mem_req, 0);
        end else begin
            age++;
            chk("busy_ready", cpu_ready, 0);
            chk("c_addr", c_addr, t_addr);
            chk("c_wdata", c_wdata, t_wdata);
            if (c_read)  o_cread++;
            if (c_write) o_cwrite++;
            if (mem_req) begin
                o_memhigh++;
                if (!prev_mreq) o_memrise++;
                o_maddr = mem_addr; o_mwdata = mem_wdata;
                chk("mem_we", mem_we, t_we);
                chk("mem_addr", mem_addr, exp_maddr);
                if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
            end
            if (c_write_line) begin
                o_wl++; o_line = c_line;
                chk("c_line", c_line, exp_line);
            end
            if (cpu_resp) begin
                o_lat = age; o_rdata = cpu_rdata;
                if (!t_we) chk("cpu_rdata", cpu_rdata, exp_rdata);
                if (!t_we && t_hit) chk("hit_latency", age, 3);
                chk("n_c_read", o_cread, t_we ? 0 : 1);
                chk("n_c_write", o_cwrite, t_we ? 1 : 0);
                chk("n_write_line", o_wl, (!t_we && !t_hit) ? 1 : 0);
                chk("n_mem_req", o_memrise, (t_we || !t_hit) ? 1 : 0);
                if (t_we || !t_hit) chk("mem_req_len", o_memhigh, ack_delay + 1);
                if (!t_we) begin
                    if (t_hit) m_hits++; else m_misses++;
                end
                outst = 1'b0;
                n_done++;
            end
        end
        prev_mreq = mem_req;
    end

    task automatic setup(input bit we, input logic [AW-1:0] addr, input logic [BS-1:0] wdata,
                         input bit hit, input logic [BS-1:0] crd, input logic [BS-1:0] beat_base,
                         input int delay);
        cfg_we = we; cfg_addr = addr; cfg_wdata = wdata; cfg_hit = hit; cfg_crdata = crd;
        for (int k = 0; k < NB; k++) cfg_beats[k] = beat_base + BS'(k);
        ack_delay = delay; beat_limit = NB; beats_sent = 0;
    endtask

    task automatic issue();
        cpu_req = 1'b1; cpu_we = cfg_we; cpu_addr = cfg_addr; cpu_wdata = cfg_wdata;
        @(negedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (outst && n < 200) begin
            @(negedge clk); n++;
        end
        @(negedge clk); #1;
        checks++;
        if (outst) begin
            errors++;
            $display("FAIL txn_timeout actual=busy required=idle at %0t", $time);
            rst_n = 1'b0; @(negedge clk); @(negedge clk); #1; rst_n = 1'b1;
        end
    endtask

    task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [BS-1:0] wdata,
                          input bit hit, input logic [BS-1:0] crd, input logic [BS-1:0] beat_base,
                          input int delay);
        setup(we, addr, wdata, hit, crd, beat_base, delay);
        issue();
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int done_before;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        setup(1'b0, '0, '0, 1'b0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Read hit
        do_txn(1'b0, 32'h10, '0, 1'b1, 32'hCAFE0001, '0, 0);
        chk("lit_hit_lat", o_lat, 3);
        chk("lit_hit_rdata", o_rdata, 32'hCAFE0001);
        chk("lit_hit_nomem", o_memrise, 0);

        // Read miss, offset 2
        do_txn(1'b0, 32'h26, '0, 1'b0, 32'hDEAD0000, 32'hA0, 0);
        chk("lit_miss_maddr", o_maddr, 32'h24);
        chk("lit_miss_line", o_line, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("lit_miss_rdata", o_rdata, 32'hA2);
        chk("lit_miss_wl", o_wl, 1);

        // Write hit and write miss
        do_txn(1'b1, 32'h08, 32'h55, 1'b1, 32'h1234, '0, 0);
        chk("lit_wh_maddr", o_maddr, 32'h08);
        chk("lit_wh_wdata", o_mwdata, 32'h55);
        chk("lit_wh_cwrite", o_cwrite, 1);
        chk("lit_wh_wl", o_wl, 0);
        do_txn(1'b1, 32'h08, 32'h55, 1'b0, 32'h1234, '0, 0);
        chk("lit_wm_maddr", o_maddr, 32'h08);
        chk("lit_wm_wl", o_wl, 0);

        // Memory stall of 5 cycles on a read miss and on a write
        do_txn(1'b0, 32'h1F, '0, 1'b0, '0, 32'hC0, 5);
        chk("lit_stall_len", o_memhigh, 6);
        chk("lit_stall_rdata", o_rdata, 32'hC3);
        do_txn(1'b1, 32'h41, 32'h77, 1'b0, '0, '0, 5);
        chk("lit_wstall_len", o_memhigh, 6);

        // Reset after the second refill beat
        setup(1'b0, 32'h26, '0, 1'b0, '0, 32'hE0, 0);
        beat_limit = 2;
        issue();
        n = 0;
        while (beats_sent < 2 && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (beats_sent < 2) begin
            errors++;
            $display("FAIL beat_wait actual=%0d required=2", beats_sent);
        end
        @(posedge clk);
        @(negedge clk); #1;
        done_before = n_done;
        chk("lit_rst_wl_before", o_wl, 0);
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("lit_rst_no_resp", n_done, done_before);
        // Request presented together with reset release must be accepted on the first edge
        setup(1'b0, 32'h26, '0, 1'b0, '0, 32'hB0, 0);
        rst_n = 1'b1;
        issue();
        wait_idle();
        chk("lit_post_rst_line", o_line, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("lit_post_rst_rdata", o_rdata, 32'hB2);

        // Miss at the last slot, then three hits
        do_txn(1'b0, 32'h33, '0, 1'b0, '0, 32'hD0, 0);
        chk("lit_last_slot", o_rdata, 32'hD3);
        do_txn(1'b0, 32'h50, '0, 1'b1, 32'h11, '0, 0);
        do_txn(1'b0, 32'h51, '0, 1'b1, 32'h22, '0, 0);
        do_txn(1'b0, 32'h52, '0, 1'b1, 32'h33, '0, 0);
        chk("lit_hit3_rdata", o_rdata, 32'h33);

`ifdef CACHE_REFILL_CTRL_PERF_EN
        chk("perf_hits_model", perf_hits, m_hits);
        chk("perf_misses_model", perf_misses, m_misses);
        chk("lit_perf_hits", perf_hits, 3);
        chk("lit_perf_misses", perf_misses, 2);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter BLOCK_SIZE, default 32, SHALL set the bits per data block.
REQ-002 Parameter NUM_OF_BLOCKS_PER_LINE, default 4, SHALL set the blocks per cache line (power of 2, at least 2).
REQ-003 Parameter ADDRESS_SIZE, default 32, SHALL set the word-address width; OFS = clog2(NUM_OF_BLOCKS_PER_LINE).
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  request strobe; accepted when cpu_ready=1.
REQ-007 cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
REQ-008 cpu_addr  in  ADDRESS_SIZE  word address; sampled with cpu_req.
REQ-009 cpu_wdata  in  BLOCK_SIZE  write data; sampled with cpu_req.
REQ-010 cpu_ready  out  1  1 only in IDLE.
REQ-011 cpu_resp  out  1  one-cycle pulse per completed request.
REQ-012 cpu_rdata  out  BLOCK_SIZE  read data, valid during the cpu_resp pulse of a read.
REQ-013 c_read, c_write, c_write_line  out  1 each  one-cycle command pulses to the cache.
REQ-014 c_addr  out  ADDRESS_SIZE  cache address, equal to the latched request address.
REQ-015 c_wdata  out  BLOCK_SIZE  block write data, equal to the latched cpu_wdata.
REQ-016 c_line  out  NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE  refill line; block k at bits [k*BLOCK_SIZE +: BLOCK_SIZE].
REQ-017 c_rdata, c_hit, c_miss  in  BLOCK_SIZE,1,1  registered cache result, valid the cycle after c_read or c_write.
REQ-018 mem_req  out  1  memory request; held until mem_ack.
REQ-019 mem_we  out  1  1=word write, 0=line read.
REQ-020 mem_addr  out  ADDRESS_SIZE  line-aligned (low OFS bits zero) for reads; word address for writes.
REQ-021 mem_wdata  out  BLOCK_SIZE  write data.
REQ-022 mem_ack  in  1  request accepted; mem_req SHALL drop the next cycle.
REQ-023 mem_rvalid, mem_rdata  in  1, BLOCK_SIZE  read beats, offset 0 first, NUM_OF_BLOCKS_PER_LINE beats per line read.

Function
REQ-024 The FSM SHALL have the states IDLE, LOOKUP, CHECK, FILL_REQ, FILL_BEAT, INSTALL, WR_MEM and RESP.
REQ-025 IDLE with cpu_req=1 SHALL latch we/addr/wdata and go to LOOKUP; all requests are blocking, one outstanding.
REQ-026 LOOKUP SHALL pulse c_read (read) or c_write (write) for one cycle, then go to CHECK.
REQ-027 On a read with c_hit=1 in CHECK, the block SHALL load cpu_rdata=c_rdata and go to RESP; a hit therefore completes with cpu_resp 3 cycles after acceptance.
REQ-028 On a read with c_miss=1 in CHECK, the block SHALL go to FILL_REQ and issue mem_req, mem_we=0, mem_addr={addr[ADDRESS_SIZE-1:OFS],0}.
REQ-029 After mem_ack, FILL_BEAT SHALL store each mem_rvalid beat into c_line slot beat_cnt; beat_cnt SHALL wrap from N-1 to 0, and on the final beat the FSM SHALL go to INSTALL.
REQ-030 INSTALL SHALL pulse c_write_line, set cpu_rdata = slot addr[OFS-1:0], and go to RESP; the cache is not re-read.
REQ-031 Writes SHALL be write-through, no-write-allocate: after CHECK on hit or miss, WR_MEM SHALL issue mem_req, mem_we=1, mem_addr=addr, mem_wdata=wdata; on mem_ack the FSM SHALL go to RESP, and a write miss SHALL NOT refill.
REQ-032 RESP SHALL pulse cpu_resp for one cycle and return to IDLE.
REQ-033 The block SHALL ignore mem_rvalid outside FILL_BEAT, and cpu_req while cpu_ready=0.
REQ-034 The block SHALL accept mem_ack in the same cycle mem_req first rises, giving a minimum one-cycle request.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE, cpu_ready=1, with all other outputs, c_line, beat_cnt and latches at 0, and in-flight requests SHALL be discarded without a cpu_resp.
REQ-036 After rst_n rises, the block SHALL accept a request in the first clk edge.

Configuration
REQ-037 With CACHE_REFILL_CTRL_PERF_EN defined, the block SHALL add outputs perf_hits and perf_misses (32 bits each), which count read CHECK outcomes, saturate at all-ones and clear on reset.
REQ-038 Without CACHE_REFILL_CTRL_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Read hit: cpu_addr=0x10, with c_hit=1 and c_rdata=0xCAFE0001 -> cpu_resp 3 cycles after acceptance with cpu_rdata=0xCAFE0001, and no mem_req.
REQ-040 Read miss: cpu_addr=0x26 with c_miss=1, then beats 0xA0..0xA3 -> mem_addr=0x24, one c_write_line with c_line={A3,A2,A1,A0}, and cpu_rdata=0xA2.
REQ-041 Write hit and write miss to 0x08 with data 0x55 -> c_write pulse, mem_we=1, mem_addr=0x08, mem_wdata=0x55, with no c_write_line in either case.
REQ-042 Memory stall: mem_ack delayed 5 cycles -> mem_req and mem_addr stable throughout, and cpu_ready=0.
REQ-043 Reset asserted after the 2nd refill beat -> IDLE, no cpu_resp, no c_write_line, and the next miss refills all 4 beats correctly.
REQ-044 PERF_EN: 3 hits and 2 misses -> perf_hits=3 and perf_misses=2.
